adc_seq: RTL

//  Conversion sequencer/averager placed directly around the SAR ADC macro (adc).

---
 rtl/adc_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/adc_seq.sv
// Conversion sequencer around the SAR ADC macro: paces start/done handshakes,
// averages 2**AVG_LOG2 samples and queues results in a small valid/ready FIFO.
module adc_seq #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned FIFO_AW  = 2,
    parameter int unsigned TMO      = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [15:0]          period,
    output logic                 adc_start,
    input  logic                 adc_done,
    input  logic [DW-1:0]        adc_data,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FIFO_AW:0]     fifo_cnt,
    output logic                 overrun,
    output logic                 timeout
);

    localparam int unsigned AW    = DW + AVG_LOG2;
    localparam int unsigned CW    = AVG_LOG2 + 1;
    localparam int unsigned NSAMP = 2 ** AVG_LOG2;
    localparam int unsigned TW    = $clog2(TMO + 1);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned FCW   = FIFO_AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_CONV  = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      scnt_q, scnt_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [15:0]        wait_q, wait_d;
    logic               done_q, done_d;
    logic               adc_start_q, adc_start_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]     fcnt_q, fcnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DW-1:0]      out_data_q, out_data_d;
    logic [DW-1:0]      mem_q [DEPTH];
    logic [DW-1:0]      mem_d [DEPTH];

    logic               done_edge;
    logic               push;
    logic               do_push;
    logic               pop;
    logic               full;
    logic [DW-1:0]      push_data;

    // Sequencer FSM with accumulator and conversion watchdog
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        scnt_d    = scnt_q;
        tmo_d     = tmo_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        push      = 1'b0;
        done_d    = adc_done;
        done_edge = adc_done & ~done_q;
        push_data = DW'(acc_q >> AVG_LOG2);

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_START;
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                if (done_edge) begin
                    acc_d   = acc_q + AW'(adc_data);
                    scnt_d  = scnt_q + CW'(1);
                    state_d = S_ACC;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    timeout_d = 1'b1;
                    acc_d     = '0;
                    scnt_d    = '0;
                    wait_d    = period;
                    state_d   = S_WAIT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_ACC: begin
                if (scnt_q == CW'(NSAMP)) begin
                    push   = 1'b1;
                    acc_d  = '0;
                    scnt_d = '0;
                end
                if (period != 16'd0) begin
                    wait_d  = period;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_START;
                end
            end
            S_WAIT: begin
                // A zero load (timeout with period 0) also leaves after one cycle
                if (wait_q <= 16'd1) state_d = S_START;
                else                 wait_d  = wait_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (!en) begin
            state_d   = S_IDLE;
            acc_d     = '0;
            scnt_d    = '0;
            timeout_d = 1'b0;
            push      = 1'b0;
        end

        adc_start_d = (state_d == S_START);
    end

    // Result FIFO; the head is re-registered so out_data holds when empty
    always_comb begin
        pop       = out_valid_q & out_ready;
        full      = (fcnt_q == FCW'(DEPTH));
        do_push   = push & (~full | pop);
        overrun_d = overrun_q;
        if (push & full & ~pop) overrun_d = 1'b1;
        if (!en)                overrun_d = 1'b0;

        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_data;

        wr_ptr_d = wr_ptr_q + FIFO_AW'(do_push);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
        fcnt_d   = fcnt_q + FCW'(do_push) - FCW'(pop);

        out_valid_d = (fcnt_d != '0);
        out_data_d  = out_data_q;
        if (fcnt_d != '0) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) out_data_d = push_data;
            else                                   out_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            scnt_q      <= '0;
            tmo_q       <= '0;
            wait_q      <= '0;
            done_q      <= 1'b0;
            adc_start_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            scnt_q      <= scnt_d;
            tmo_q       <= tmo_d;
            wait_q      <= wait_d;
            done_q      <= done_d;
            adc_start_q <= adc_start_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
        end
    end

    assign adc_start = adc_start_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign fifo_cnt  = fcnt_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

endmodule
